sensor_stream_arbiter: RTL and testbench

Round-robin AXI-Stream arbiter that merges up to eight sensor monitor streams into one 32-bit output stream. It sits between the per-sensor monitor blocks (temperature, VCCINT, auxiliary channels, each emitting `{16'h0000, value}` beats) and the single downstream consumer (UART formatter / FIFO). It tags every forwarded beat with its source ID in the reserved upper byte, so the consumer can demultiplex.

---
 rtl/sensor_stream_arbiter.sv | 102 ++++++++++
 tb/tb_sensor_stream_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_stream_arbiter.sv
// Round-robin merge of NUM_SRC sensor streams into one 32-bit stream.
// Each beat is tagged with its source ID in bits [31:24].
module sensor_stream_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [32*NUM_SRC-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]    s_axis_tvalid,
  output logic [NUM_SRC-1:0]    s_axis_tready,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [15:0]           beat_count,
  output logic [2:0]            last_src
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state_q, state_d;

  logic [31:0]          data_q;
  logic [2:0]           ptr_q;
  logic [2:0]           last_q;
  logic [15:0]          beat_q;

  logic [2*NUM_SRC-1:0] vld2;
  logic [2*NUM_SRC-1:0] vld_rot_w;
  logic [NUM_SRC-1:0]   vld_rot;
  int unsigned          base;
  int unsigned          off;
  int unsigned          sum;
  logic                 grant_vld;
  logic [2:0]           grant;
  logic [23:0]          grant_data;
  logic                 load_en;
  logic                 in_hs;
  logic                 out_hs;
  logic                 unused_hi;

  // Rotate valids so bit 0 is the source right after ptr, then take the lowest set bit.
  always_comb begin
    vld2      = {s_axis_tvalid, s_axis_tvalid};
    base      = 32'(ptr_q) + 1;
    vld_rot_w = vld2 >> base;
    vld_rot   = vld_rot_w[NUM_SRC-1:0];
    grant_vld = |vld_rot;
    off       = 0;
    for (int unsigned j = NUM_SRC; j > 0; j--) begin
      if (vld_rot[j-1]) off = j - 1;
    end
    sum = base + off;
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    grant = 3'(sum);
  end

  always_comb begin
    load_en       = (state_q == EMPTY) || m_axis_tready;
    s_axis_tready = '0;
    grant_data    = '0;
    unused_hi     = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant == 3'(i)) grant_data = s_axis_tdata[32*i +: 24];
      unused_hi = unused_hi ^ (^s_axis_tdata[32*i+24 +: 8]);
      if (!reset && load_en && grant_vld && (grant == 3'(i))) s_axis_tready[i] = 1'b1;
    end
    in_hs         = |s_axis_tready;
    // Gating with reset keeps a held beat from handshaking in the reset cycle.
    m_axis_tvalid = (state_q == FULL) && !reset;
    out_hs        = m_axis_tvalid && m_axis_tready;
    state_d       = state_q;
    if (in_hs)       state_d = FULL;
    else if (out_hs) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      ptr_q  <= 3'(NUM_SRC - 1);
      last_q <= '0;
      beat_q <= '0;
    end else begin
      if (in_hs) begin
        data_q <= {ID_W'(grant), grant_data};
        ptr_q  <= grant;
        last_q <= grant;
      end
      if (out_hs) beat_q <= beat_q + 16'd1;
    end
  end

  assign m_axis_tdata = data_q;
  assign beat_count   = beat_q;
  assign last_src     = last_q;

endmodule

// File: tb/tb_sensor_stream_arbiter.sv
// Directed bench for sensor_stream_arbiter: queued expected beats are
// compared by a monitor on every output handshake.
module tb_sensor_stream_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [32*N-1:0] s_tdata;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tready;
  logic [31:0]    m_tdata;
  logic           m_tvalid;
  logic           m_tready;
  logic [15:0]    beat_count;
  logic [2:0]     last_src;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  logic [3:0]  rdy_tab[4] = '{4'b1000, 4'b0001, 4'b1000, 4'b0000};
  logic [15:0] cnt_tab[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

  always #5 clk = ~clk;

  sensor_stream_arbiter #(.NUM_SRC(N), .ID_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .beat_count   (beat_count),
    .last_src     (last_src)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [31:0] d);
    s_tdata[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    next_cycle();
    reset    = 1'b1;
    s_tvalid = '0;
    @(negedge clk);
    chk("reset_pulse_m_tvalid", 32'(m_tvalid), 32'd0);
    next_cycle();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%h required=none", m_tdata);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_beat", m_tdata, mon_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    s_tdata  = '0;
    s_tvalid = '1;
    m_tready = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, 32'h0000_0050 + 32'(i));

    // Reset held with every source valid
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    end
    #1 reset = 1'b0;
    #2;
    chk("post_rst_s_tready", 32'(s_tready), 32'h1);
    chk("post_rst_beat_count", 32'(beat_count), 32'd0);
    s_tvalid = '0;

    // Single source 2
    next_cycle();
    set_src(2, 32'h0000_0019);
    s_tvalid = 4'b0100;
    exp_q.push_back(32'h0200_0019);
    @(negedge clk);
    chk("single_s_tready", 32'(s_tready), 32'h4);
    chk("single_pre_tvalid", 32'(m_tvalid), 32'd0);
    next_cycle();
    s_tvalid = '0;
    @(negedge clk);
    chk("single_m_tvalid", 32'(m_tvalid), 32'd1);
    chk("single_m_tdata", m_tdata, 32'h0200_0019);
    chk("single_beat_before", 32'(beat_count), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("single_tvalid_drop", 32'(m_tvalid), 32'd0);
    chk("single_beat_count", 32'(beat_count), 32'd1);
    chk("single_last_src", 32'(last_src), 32'd2);

    // Fairness: all four valid, upper byte garbage must be replaced by the tag
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 32'hEE12_3400 + 32'(i));
    for (int k = 0; k < 16; k++)
      exp_q.push_back((32'(k % 4) << 24) | (32'h0012_3400 + 32'(k % 4)));
    s_tvalid = '1;
    m_tready = 1'b1;
    @(negedge clk);
    chk("fair_first_grant", 32'(s_tready), 32'h1);
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      if (k == 15) s_tvalid = '0;
      @(negedge clk);
      chk("fair_m_tvalid", 32'(m_tvalid), 32'd1);
    end
    next_cycle();
    @(negedge clk);
    chk("fair_beat_count", 32'(beat_count), 32'd16);
    chk("fair_idle", 32'(m_tvalid), 32'd0);
    chk("fair_last_src", 32'(last_src), 32'd3);

    // Back-pressure: source 1 held while 0 and 3 wait
    set_src(1, 32'h0000_0042);
    s_tvalid = 4'b0010;
    m_tready = 1'b0;
    exp_q.push_back(32'h0100_0042);
    next_cycle();
    set_src(0, 32'h0000_0111);
    set_src(3, 32'h0000_0333);
    s_tvalid = 4'b1001;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_m_tdata", m_tdata, 32'h0100_0042);
      chk("bp_m_tvalid", 32'(m_tvalid), 32'd1);
      chk("bp_s_tready", 32'(s_tready), 32'd0);
      next_cycle();
    end
    m_tready = 1'b1;
    exp_q.push_back(32'h0300_0333);
    exp_q.push_back(32'h0000_0111);
    @(negedge clk);
    chk("bp_release_grant", 32'(s_tready), 32'h8);
    next_cycle();
    s_tvalid = 4'b0001;
    @(negedge clk);
    chk("bp_second_grant", 32'(s_tready), 32'h1);
    next_cycle();
    s_tvalid = '0;
    next_cycle();
    @(negedge clk);
    chk("bp_drained", 32'(m_tvalid), 32'd0);
    chk("bp_last_src", 32'(last_src), 32'd0);

    // Skip and wrap, with beat_count crossing 0xFFFF
    do_reset();
    force dut.beat_q = 16'hFFFE;
    #1 release dut.beat_q;
    set_src(0, 32'h0000_0AAA);
    set_src(3, 32'h0000_0BBB);
    s_tvalid = 4'b1001;
    m_tready = 1'b1;
    exp_q.push_back(32'h0000_0AAA);
    exp_q.push_back(32'h0300_0BBB);
    exp_q.push_back(32'h0000_0AAA);
    exp_q.push_back(32'h0300_0BBB);
    @(negedge clk);
    chk("wrap_preload", 32'(beat_count), 32'h0000_FFFE);
    chk("wrap_first_grant", 32'(s_tready), 32'h1);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 3) s_tvalid = '0;
      @(negedge clk);
      chk("wrap_s_tready", 32'(s_tready), 32'(rdy_tab[k]));
      chk("wrap_beat_count", 32'(beat_count), 32'(cnt_tab[k]));
    end
    next_cycle();
    @(negedge clk);
    chk("wrap_final_count", 32'(beat_count), 32'h0000_0002);
    chk("wrap_idle", 32'(m_tvalid), 32'd0);

    // Reset while FULL and stalled: held beat must vanish
    set_src(2, 32'h0000_0777);
    s_tvalid = 4'b0100;
    m_tready = 1'b0;
    next_cycle();
    s_tvalid = '0;
    @(negedge clk);
    chk("midrst_held_valid", 32'(m_tvalid), 32'd1);
    chk("midrst_held_data", m_tdata, 32'h0200_0777);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_reset_valid", 32'(m_tvalid), 32'd0);
    chk("midrst_in_reset_ready", 32'(s_tready), 32'd0);
    next_cycle();
    reset    = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    chk("midrst_after_valid", 32'(m_tvalid), 32'd0);
    chk("midrst_beat_count", 32'(beat_count), 32'd0);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("midrst_still_idle", 32'(m_tvalid), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
